keypad_responder: RTL
=====================

# keypad_responder

Behavioural 4x4 matrix-keypad responder: the device side of the row-scan/column-sense interface driven by the `keypad` scanner. It accepts queued key codes, holds each key "pressed" for a programmable time, and answers the scanner's active-low row drive with the matching active-low column pattern. It replaces the physical keypad in bench and self-test builds, so stopwatch and calculator key sequences (0–15) run unattended.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1000: clock cycles a key stays pressed (≥1).
- `GAP_CYCLES`, default 1000: released cycles after each key before the next press (≥1).
- `FIFO_DEPTH`, default 4: key-request queue depth (power of 2, ≥2).
- `BOUNCE_CYCLES`, default 8: bounce window length; used only with `KEYPAD_BOUNCE_EN`.

Ports:
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `LINE` input 4: row drive from the scanner, active-low; `LINE[r]`=0 selects row r.
- `COLLUMMN` output 4: column sense to the scanner, active-low, idle 4'hF.
- `key_code` input 4: key to press (0–9 digits, 10=A, 11=B, 12=C, 13=D, 14=*, 15=#).
- `key_valid` input 1: request strobe; accepted when `key_valid && key_ready`.
- `key_ready` output 1: queue not full.
- `busy` output 1: high in PRESS or GAP, or when the queue is non-empty.
- `press_done` output 1: one-cycle pulse at the end of each key's GAP.
- `press_count` output 8: completed presses, wraps 255→0.

## Operation
- Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D. Example: code 0 is r3c1; code 14 is r3c0.
- Queue: FIFO of `FIFO_DEPTH` 4-bit codes. Push on `key_valid && key_ready`. `key_ready` = !full, registered from occupancy.
  - A pop in the same cycle does not raise `key_ready` until the next cycle.
  - `key_valid` while full is ignored; no overwrite.
- FSM states IDLE, PRESS, GAP:
  - IDLE→PRESS when the queue is non-empty. Pop the head into `cur_key` and load the hold counter.
  - PRESS→GAP after `HOLD_CYCLES` cycles in PRESS. Load the gap counter.
  - GAP→IDLE after `GAP_CYCLES` cycles. Pulse `press_done` and increment `press_count`, both on the GAP→IDLE transition.
- Column response (combinational from `LINE` and registered state):
  - In PRESS, `COLLUMMN[c(cur_key)]` = 0 iff `LINE[r(cur_key)]` = 0. All other bits are 1.
  - In IDLE and GAP, `COLLUMMN` = 4'hF.
  - Multiple low `LINE` bits are legal; the response depends only on the pressed key's row.
- Only one key is ever pressed at a time. No ghosting or multi-key emulation.
- Reset (any state, including mid-PRESS) clears the FIFO, FSM→IDLE, counters→0. `COLLUMMN` releases combinationally on the cycle after the reset edge.

## Timing
- Reset values: `COLLUMMN`=4'hF, `key_ready`=1, `busy`=0, `press_done`=0, `press_count`=0.
- Latency from acceptance in IDLE with an empty queue:
  - Push at edge N → FIFO non-empty after N.
  - PRESS entered at edge N+1.
  - `COLLUMMN` responds from cycle N+1 through edge N+1+`HOLD_CYCLES`.
- Key period = 1 (IDLE) + `HOLD_CYCLES` + `GAP_CYCLES` cycles. Back-to-back queued keys spend exactly one cycle in IDLE.
- `LINE`→`COLLUMMN` is zero-cycle combinational, so the scanner sees the response within its own sample cycle.
- `busy` is registered and consistent with state and occupancy after each edge.

## Configuration
- `KEYPAD_BOUNCE_EN` defined:
  - The first `BOUNCE_CYCLES` of PRESS and the first `BOUNCE_CYCLES` of GAP emulate contact bounce.
  - In those windows the pressed-key contact is closed on even cycle offsets (offset 0 closed) and open on odd offsets.
  - In the GAP window, a closed contact pulls the column low exactly as in PRESS.
  - Hold and gap durations are unchanged.
- Not defined: clean contact. Closed for all of PRESS, open for all of GAP, no bounce logic synthesized.

## Test plan
- Reset, `LINE`=4'b1110 → `COLLUMMN`=4'hF, `key_ready`=1, `busy`=0, `press_count`=0.
- HOLD=4, GAP=3; push code 5 at edge N; cycle `LINE` through 1110/1101/1011/0111.
  - `COLLUMMN`=4'b1101 only while `LINE`=1101, during cycles N+1..N+4.
  - `press_done` pulses at edge N+8; `press_count`=1.
- Push 11, 0, 14, 13 back-to-back with HOLD=2, GAP=2:
  - Rows/columns observed in order: r1c3, r3c1, r3c0, r3c3.
  - Key periods of 5 cycles each; `press_count`=4.
- FIFO_DEPTH=4: 5 pushes while the FSM holds a key in PRESS → `key_ready` low after the 4th; the 5th is dropped; exactly 5 presses complete (1 pressed + 4 queued).
- Assert `rst` mid-PRESS of key 9 with `LINE`=4'b1011 → the next cycle `COLLUMMN`=4'hF, queue empty, `busy`=0, no `press_done`.
- With `KEYPAD_BOUNCE_EN`, BOUNCE=4, key 1, `LINE`=1110 → `COLLUMMN[0]` pattern 0,1,0,1 at PRESS start, then steady 0; 0,1,0,1 at GAP start, then steady 1.

Source files
------------

// File: rtl/keypad_responder_if.sv
// ============================================================================
// Module   : keypad_responder_if
// Brief    : Scanner-side and request-side signals of the keypad responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface keypad_responder_if;
    logic [3:0] LINE;
    logic [3:0] COLLUMMN;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       press_done;
    logic [7:0] press_count;

    modport master (
        output LINE, key_code, key_valid,
        input  COLLUMMN, key_ready, busy, press_done, press_count
    );

    modport slave (
        input  LINE, key_code, key_valid,
        output COLLUMMN, key_ready, busy, press_done, press_count
    );
endinterface

`default_nettype wire

// File: rtl/keypad_responder.sv
// ============================================================================
// Module   : keypad_responder
// Brief    : Emulated 4x4 keypad; presses queued key codes and answers the
//            active-low row scan. Optional contact bounce: KEYPAD_BOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_responder #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 1000,
    parameter int FIFO_DEPTH    = 4,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_responder_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);

    generate
        if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BOUNCE_CYCLES < 0) begin : g_bad_params
            $error("keypad_responder: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_fifo [FIFO_DEPTH];
    logic [c_OCC_W-1:0]   r_wr_ptr;
    logic [c_OCC_W-1:0]   r_rd_ptr;
    logic [3:0]           r_cur_key;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_key_ready;
    logic                 r_busy;
    logic                 r_press_done;
    logic [7:0]           r_press_count;

    logic [c_OCC_W-1:0]   w_occ;
    logic [c_OCC_W-1:0]   w_occ_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load_cnt;
    logic                 w_done;
    logic                 w_hold_end;
    logic                 w_gap_end;
    logic [1:0]           w_row;
    logic [1:0]           w_col;
    logic                 w_closed;
    logic [3:0]           w_cols;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_push     = bus.key_valid && r_key_ready;
    assign w_occ_nxt  = w_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);
    assign w_hold_end = (r_cnt == c_CNT_W'(HOLD_CYCLES - 1));
    assign w_gap_end  = (r_cnt == c_CNT_W'(GAP_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_cnt  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_occ != '0) begin
                    w_state_nxt = S_PRESS;
                    w_pop       = 1'b1;
                    w_load_cnt  = 1'b1;
                end
            end
            S_PRESS: begin
                if (w_hold_end) begin
                    w_state_nxt = S_GAP;
                    w_load_cnt  = 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cur_key     <= '0;
            r_cnt         <= '0;
            r_key_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_press_done  <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_key_ready  <= (w_occ_nxt != c_OCC_W'(FIFO_DEPTH));
            r_busy       <= (w_state_nxt != S_IDLE) || (w_occ_nxt != '0);
            r_press_done <= w_done;
            r_cnt        <= w_load_cnt ? '0 : r_cnt + c_CNT_W'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_OCC_W'(1);
            end
            if (w_pop) begin
                r_cur_key <= r_fifo[r_rd_ptr[c_PTR_W-1:0]];
                r_rd_ptr  <= r_rd_ptr + c_OCC_W'(1);
            end
            if (w_done) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= bus.key_code;
        end
    end

    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_cur_key)
            4'd1:  begin w_row = 2'd0; w_col = 2'd0; end
            4'd2:  begin w_row = 2'd0; w_col = 2'd1; end
            4'd3:  begin w_row = 2'd0; w_col = 2'd2; end
            4'd10: begin w_row = 2'd0; w_col = 2'd3; end
            4'd4:  begin w_row = 2'd1; w_col = 2'd0; end
            4'd5:  begin w_row = 2'd1; w_col = 2'd1; end
            4'd6:  begin w_row = 2'd1; w_col = 2'd2; end
            4'd11: begin w_row = 2'd1; w_col = 2'd3; end
            4'd7:  begin w_row = 2'd2; w_col = 2'd0; end
            4'd8:  begin w_row = 2'd2; w_col = 2'd1; end
            4'd9:  begin w_row = 2'd2; w_col = 2'd2; end
            4'd12: begin w_row = 2'd2; w_col = 2'd3; end
            4'd14: begin w_row = 2'd3; w_col = 2'd0; end
            4'd0:  begin w_row = 2'd3; w_col = 2'd1; end
            4'd15: begin w_row = 2'd3; w_col = 2'd2; end
            default: begin w_row = 2'd3; w_col = 2'd3; end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    logic w_in_bounce;
    // r_cnt is the cycle offset within the current PRESS or GAP phase.
    assign w_in_bounce = (32'(r_cnt) < BOUNCE_CYCLES);

    always_comb begin
        w_closed = 1'b0;
        case (r_state)
            S_PRESS: w_closed = !(w_in_bounce && r_cnt[0]);
            S_GAP:   w_closed = w_in_bounce && !r_cnt[0];
            default: w_closed = 1'b0;
        endcase
    end
`else
    assign w_closed = (r_state == S_PRESS);
`endif

    always_comb begin
        w_cols = 4'hF;
        if (w_closed && !bus.LINE[w_row]) begin
            w_cols[w_col] = 1'b0;
        end
    end

    assign bus.COLLUMMN    = w_cols;
    assign bus.key_ready   = r_key_ready;
    assign bus.busy        = r_busy;
    assign bus.press_done  = r_press_done;
    assign bus.press_count = r_press_count;

endmodule

`default_nettype wire
